vga_tile_display: RTL

//  Parametrised VGA display engine: sync timing, tile-map reads and palette colour.

---
 rtl/vga_tile_display.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_tile_display.sv
// VGA display engine: parametrised sync timing, per-pixel tile-map reads and palette lookup.
// Three-slot pipeline (address, tile capture, colour) keeps RGB and both syncs aligned.
module vga_tile_display #(
    parameter int   PIX_DIV   = 2,
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CW        = 4,
    parameter int   TW        = 2,
    parameter int   TS        = 5,
    parameter int   GRID_COLS = 20,
    parameter int   GRID_ROWS = 15,
    parameter int   AW        = 10,
    parameter logic [3*CW*(2**TW)-1:0] PALETTE    = 48'hF00_FF0_0F0_000,
    parameter logic [3*CW-1:0]         BORDER_RGB = 12'h444
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] rdata,
    output logic          re,
    output logic [AW-1:0] raddr,
    output logic [CW-1:0] R_out,
    output logic [CW-1:0] G_out,
    output logic [CW-1:0] B_out,
    output logic          HSync,
    output logic          VSync,
    output logic          vblank,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int PW      = 3 * CW;

    logic [DW-1:0] div;
    logic [HW-1:0] h, h_nx;
    logic [VW-1:0] v, v_nx;
    logic          pix_en, h_wrap, v_wrap;

    logic          n_active, n_in_grid, n_hs, n_vs;
    logic [AW-1:0] row_a, col_a, n_addr;

    logic          s0_active, s0_in_grid, s0_hs, s0_vs;
    logic          s1_active, s1_in_grid, s1_hs, s1_vs;
    logic [TW-1:0] s1_tile;
    logic [PW-1:0] pix_rgb, rgb_q;

    assign pix_en = (div == DW'(PIX_DIV - 1));
    assign h_wrap = (h == HW'(H_TOTAL - 1));
    assign v_wrap = (v == VW'(V_TOTAL - 1));
    assign vblank = (int'(v) >= V_ACTIVE);

    assign R_out = rgb_q[PW-1 -: CW];
    assign G_out = rgb_q[2*CW-1 -: CW];
    assign B_out = rgb_q[CW-1:0];

    // Stage 0 classifies the slot the counters are about to enter, so the read
    // goes out on the same edge that moves the counters there.
    always_comb begin
        h_nx = h_wrap ? '0 : h + HW'(1);
        v_nx = v;
        if (h_wrap) begin
            v_nx = v_wrap ? '0 : v + VW'(1);
        end
        n_active  = (int'(h_nx) < H_ACTIVE) && (int'(v_nx) < V_ACTIVE);
        n_hs      = (int'(h_nx) >= H_ACTIVE + H_FP) && (int'(h_nx) < H_ACTIVE + H_FP + H_SYNC);
        n_vs      = (int'(v_nx) >= V_ACTIVE + V_FP) && (int'(v_nx) < V_ACTIVE + V_FP + V_SYNC);
        n_in_grid = n_active && (int'(h_nx >> TS) < GRID_COLS) && (int'(v_nx >> TS) < GRID_ROWS);
        col_a     = AW'(h_nx >> TS);
        row_a     = AW'(v_nx >> TS);
        n_addr    = row_a * AW'(GRID_COLS) + col_a;
    end

    always_comb begin
        pix_rgb = PALETTE[int'(s1_tile) * PW +: PW];
        if (!s1_in_grid) begin
            pix_rgb = BORDER_RGB;
        end
        if (!s1_active) begin
            pix_rgb = '0;
        end
    end

    // All state, counters and pipeline alike, advances only on pix_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            re          <= 1'b0;
            raddr       <= '0;
            frame_start <= 1'b0;
            s0_active   <= 1'b0;
            s0_in_grid  <= 1'b0;
            s0_hs       <= 1'b0;
            s0_vs       <= 1'b0;
            s1_active   <= 1'b0;
            s1_in_grid  <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_tile     <= '0;
            rgb_q       <= '0;
            HSync       <= ~SYNC_POL;
            VSync       <= ~SYNC_POL;
        end else begin
            re          <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                div         <= '0;
                h           <= h_nx;
                v           <= v_nx;
                frame_start <= h_wrap && v_wrap;
                re          <= n_in_grid;
                if (n_in_grid) begin
                    raddr <= n_addr;
                end
                s0_active  <= n_active;
                s0_in_grid <= n_in_grid;
                s0_hs      <= n_hs;
                s0_vs      <= n_vs;
                s1_active  <= s0_active;
                s1_in_grid <= s0_in_grid;
                s1_hs      <= s0_hs;
                s1_vs      <= s0_vs;
                s1_tile    <= rdata;
                rgb_q      <= pix_rgb;
                HSync      <= s1_hs ^ ~SYNC_POL;
                VSync      <= s1_vs ^ ~SYNC_POL;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule
